// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. RX is double-flopped, the start bit is confirmed at its
// midpoint, data and stop bits are sampled one bit period apart from there. A completed byte
// raises rdy until the consumer pulses clr_rdy; a byte arriving while rdy is still set raises
// the sticky overrun flag. A low stop bit raises frm_err and parks the receiver until the
// line returns high, so a held-low line (break) yields a single error, not a stream of frames.
module uart_rx #(
  parameter int unsigned BAUD_DIV = 43,  // clocks per bit
  parameter int unsigned HALF_DIV = 21   // clocks from start detection to start-bit midpoint
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       overrun
);

  localparam logic [5:0] HalfCnt  = 6'(HALF_DIV);
  localparam logic [5:0] BaudLast = 6'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHi
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_s;
  logic [5:0]  baud_cnt_q, baud_cnt_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rdy_q, rdy_d;
  logic        frm_err_q, frm_err_d;
  logic        overrun_q, overrun_d;

  logic        baud_last;
  logic        good_stop;

  // Two-flop synchronizer; only rx_s is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s      <= rx_meta_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign baud_last = (baud_cnt_q == BaudLast);

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        // A line back high at the midpoint is treated as a glitch.
        if (baud_cnt_q == HalfCnt) state_d = rx_s ? StIdle : StData;
      end
      StData: begin
        if (baud_last && (bit_cnt_q == 4'd7)) state_d = StStop;
      end
      StStop: begin
        if (baud_last) state_d = rx_s ? StIdle : StWaitHi;
      end
      StWaitHi: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter, shift register and status next-state.
  always_comb begin
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rdy_d      = rdy_q;
    frm_err_d  = frm_err_q;
    overrun_d  = overrun_q;
    good_stop  = 1'b0;

    case (state_q)
      StStart: baud_cnt_d = baud_cnt_q + 6'd1;
      StData: begin
        if (baud_last) begin
          baud_cnt_d = '0;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          shift_d    = {rx_s, shift_q[7:1]};
        end else begin
          baud_cnt_d = baud_cnt_q + 6'd1;
        end
      end
      StStop: baud_cnt_d = baud_cnt_q + 6'd1;
      default: ;
    endcase

    // Both counters restart on every state entry, so none can run past a bit period.
    if (state_d != state_q) begin
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end

    if ((state_q == StIdle) && !rx_s) frm_err_d = 1'b0;

    if ((state_q == StStop) && baud_last) begin
      if (rx_s) begin
        good_stop = 1'b1;
        rx_data_d = shift_q;
        frm_err_d = 1'b0;
      end else begin
        frm_err_d = 1'b1;
      end
    end

    // A new byte wins over a coincident acknowledge: rdy stays up, no overrun.
    if (good_stop) begin
      rdy_d = 1'b1;
      if (rdy_q && !clr_rdy) overrun_d = 1'b1;
      else if (clr_rdy)      overrun_d = 1'b0;
    end else if (clr_rdy) begin
      rdy_d     = 1'b0;
      overrun_d = 1'b0;
    end
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rdy_q      <= 1'b0;
      frm_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
      frm_err_q  <= frm_err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_err_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, scoreboard of expected output events checked by a
// separate monitor, plus direct checks for reset, latency, glitch, break and overrun cases.
module tb_uart_rx;

  localparam int unsigned BaudDiv  = 43;
  localparam int unsigned HalfDiv  = 21;
  // Edges from the RX falling edge to rdy high: sync (2) + IDLE detect (1) + frame.
  localparam int unsigned FrameLat = HalfDiv + 1 + 9 * BaudDiv + 3;  // 412

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       overrun;

  // Expected output snapshot at an event: {rx_data, frm_err, overrun, rdy}.
  typedef logic [10:0] exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;

  uart_rx #(
    .BAUD_DIV(BaudDiv),
    .HALF_DIV(HalfDiv)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (rx),
    .clr_rdy(clr_rdy),
    .rx_data(rx_data),
    .rdy    (rdy),
    .frm_err(frm_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called #1 after a posedge; returns #1 after a posedge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BaudDiv) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BaudDiv) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (BaudDiv) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Monitor: an output event is a new byte, a new framing error or a new overrun.
  initial begin
    logic       p_rdy, p_fe, p_ov;
    logic [7:0] p_data;
    exp_t       e;
    p_rdy = 1'b0; p_fe = 1'b0; p_ov = 1'b0; p_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n && ((rdy && !p_rdy) || (frm_err && !p_fe) || (overrun && !p_ov) ||
                    (rdy && p_rdy && (rx_data != p_data)))) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_event: got {data,fe,ov,rdy}=%0h with nothing expected (t=%0t)",
                   {rx_data, frm_err, overrun, rdy}, $time);
        end else begin
          e = exp_q.pop_front();
          check("event {data,fe,ov,rdy}", {21'b0, rx_data, frm_err, overrun, rdy}, {21'b0, e});
        end
      end
      p_rdy = rdy; p_fe = frm_err; p_ov = overrun; p_data = rx_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  ok;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rdy", rdy, 1'b0);
    check("reset_frm_err", frm_err, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    idle(5);

    // 8'hA5 with latency measurement, then acknowledge.
    exp_q.push_back({8'hA5, 1'b0, 1'b0, 1'b1});
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int i = 1; i <= 600; i++) begin
          @(posedge clk);
          #1;
          if (rdy) begin
            lat = i;
            break;
          end
        end
      end
    join
    check("a5_latency", lat, FrameLat);
    pulse_clr();
    check("a5_clr_rdy", rdy, 1'b0);
    idle(10);

    // Back-to-back 00, FF, 55 with an acknowledge after each.
    exp_q.push_back({8'h00, 1'b0, 1'b0, 1'b1});
    exp_q.push_back({8'hFF, 1'b0, 1'b0, 1'b1});
    exp_q.push_back({8'h55, 1'b0, 1'b0, 1'b1});
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          wait_rdy(ok);
          check("b2b_rdy_seen", ok, 1'b1);
          pulse_clr();
        end
      end
    join
    idle(10);
    check("b2b_overrun", overrun, 1'b0);

    // 10-cycle glitch on idle line.
    rx = 1'b0;
    idle(10);
    rx = 1'b1;
    idle(100);
    check("glitch_rdy", rdy, 1'b0);
    check("glitch_rx_data", rx_data, 8'h55);
    check("glitch_frm_err", frm_err, 1'b0);

    // 8'h3C with low stop bit, then break held 500 cycles.
    exp_q.push_back({8'h55, 1'b1, 1'b0, 1'b0});
    send_frame(8'h3C, 1'b0);
    idle(500);
    check("break_frm_err", frm_err, 1'b1);
    check("break_rdy", rdy, 1'b0);
    check("break_rx_data", rx_data, 8'h55);
    rx = 1'b1;
    idle(20);

    // 11 then 22 without acknowledge: overrun.
    exp_q.push_back({8'h11, 1'b0, 1'b0, 1'b1});
    exp_q.push_back({8'h22, 1'b0, 1'b1, 1'b1});
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(5);
    check("ovr_rx_data", rx_data, 8'h22);
    check("ovr_overrun", overrun, 1'b1);
    pulse_clr();
    check("ovr_clr_rdy", rdy, 1'b0);
    check("ovr_clr_overrun", overrun, 1'b0);
    idle(10);

    // Same pair, acknowledge coincident with the second stop sample.
    exp_q.push_back({8'h11, 1'b0, 1'b0, 1'b1});
    exp_q.push_back({8'h22, 1'b0, 1'b0, 1'b1});
    fork
      begin
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
      end
      begin
        repeat (BaudDiv * 10 + FrameLat - 1) @(posedge clk);
        #1;
        clr_rdy = 1'b1;
        @(posedge clk);
        #1;
        clr_rdy = 1'b0;
      end
    join
    idle(5);
    check("coinc_rdy", rdy, 1'b1);
    check("coinc_overrun", overrun, 1'b0);
    check("coinc_rx_data", rx_data, 8'h22);
    pulse_clr();
    idle(10);

    // Reset during data bit 4 of a frame.
    rx = 1'b0;
    idle(BaudDiv);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0) ? 1'b0 : 1'b1;
      idle(BaudDiv);
    end
    rx = 1'b1;
    idle(20);
    rst_n = 1'b0;
    idle(3);
    check("midrst_rx_data", rx_data, 8'h00);
    check("midrst_rdy", rdy, 1'b0);
    check("midrst_frm_err", frm_err, 1'b0);
    check("midrst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    idle(100);
    check("midrst_no_frame", rdy, 1'b0);
    exp_q.push_back({8'h7E, 1'b0, 1'b0, 1'b1});
    send_frame(8'h7E, 1'b1);
    idle(20);
    check("final_rx_data", rx_data, 8'h7E);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
